// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipeline_pkg;

    // Sequencer states: normal operation, or flushing after a redirect.
    typedef enum logic [0:0] {
        PS_IDLE  = 1'b0,
        PS_FLUSH = 1'b1
    } pipe_state_t;

    // Default number of pipeline stages (fetch .. writeback).
    localparam int STAGE_NUM_DEFAULT = 5;

    // Default boot vector loaded into the redirect target register.
    localparam logic [31:0] RST_PC_DEFAULT = 32'hbfc0_0000;

endpackage : pipeline_pkg

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;

    // Count register: clear first, then increment until all-ones is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= ZERO_VAL;
        end else if (clr) begin
            count_r <= ZERO_VAL;
        end else if (inc && (count_r != MAX_VAL)) begin
            count_r <= count_r + ONE_VAL;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer: merges per-stage stall requests with
// back-pressure, stretches a one-cycle exception into a multi-cycle flush
// with a one-cycle PC redirect, and counts fetch-stall cycles.
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int                    STAGE_NUM  = STAGE_NUM_DEFAULT,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FLUSH_HOLD = 2,
    parameter logic [ADDR_WIDTH-1:0] RST_PC     = ADDR_WIDTH'(RST_PC_DEFAULT),
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAGE_NUM-1:0]  stall_req,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_target,
    input  logic                  cnt_clr,
    output logic [STAGE_NUM-1:0]  stall,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    // Hold counter only needs to reach FLUSH_HOLD-1; keep at least one bit.
    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [STAGE_NUM-1:0] STALL_NONE = {STAGE_NUM{1'b0}};

    pipe_state_t            state_r;
    pipe_state_t            state_nxt_s;
    logic [HOLD_W-1:0]      hold_r;
    logic [HOLD_W-1:0]      hold_nxt_s;
    logic                   accept_s;
    logic                   flush_r;
    logic                   redirect_valid_r;
    logic [ADDR_WIDTH-1:0]  redirect_pc_r;
    logic [STAGE_NUM-1:0]   merged_s;
    logic [STAGE_NUM-1:0]   stall_s;

    // Next-state logic: accept an exception only from IDLE, then count down the hold.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        accept_s    = 1'b0;
        case (state_r)
            PS_IDLE: begin
                if (exc_valid) begin
                    state_nxt_s = PS_FLUSH;
                    hold_nxt_s  = HOLD_LOAD;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = PS_IDLE;
                    hold_nxt_s  = HOLD_ZERO;
                end
            end
            PS_FLUSH: begin
                // Any exc_valid here is ignored: upstream is being flushed.
                if (hold_r == HOLD_ZERO) begin
                    state_nxt_s = PS_IDLE;
                    hold_nxt_s  = HOLD_ZERO;
                end else begin
                    state_nxt_s = PS_FLUSH;
                    hold_nxt_s  = hold_r - HOLD_ONE;
                end
            end
            default: begin
                state_nxt_s = PS_IDLE;
                hold_nxt_s  = HOLD_ZERO;
            end
        endcase
    end

    // State and hold-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= PS_IDLE;
            hold_r  <= HOLD_ZERO;
        end else begin
            state_r <= state_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // Output registers so flush/redirect have no combinational path from inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= RST_PC;
        end else begin
            flush_r          <= (state_nxt_s == PS_FLUSH);
            redirect_valid_r <= accept_s;
            if (accept_s) begin
                redirect_pc_r <= exc_target;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    // Back-pressure merge: a stage stalls if it or any later stage requests a stall.
    always_comb begin : merge_blk
        logic acc_v;
        acc_v    = 1'b0;
        merged_s = STALL_NONE;
        for (int i = STAGE_NUM - 1; i >= 0; i--) begin
            acc_v       = acc_v | stall_req[i];
            merged_s[i] = acc_v;
        end
    end

    // Stall is suppressed while flushing or while reset is asserted.
    always_comb begin
        stall_s = STALL_NONE;
        if (!rst || flush_r) begin
            stall_s = STALL_NONE;
        end else begin
            stall_s = merged_s;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (stall_s[0]),
        .count (stall_cycles)
    );

    assign stall          = stall_s;
    assign flush          = flush_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

endmodule : pipeline_controller

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the in-order front/back pipeline.
- Merges per-stage stall requests into a per-stage stall vector, with later stages back-pressuring earlier ones.
- Turns a single-cycle exception/redirect request into a multi-cycle flush pulse plus a one-cycle PC redirect.
- Keeps a saturating stall-cycle performance counter.
- Its `stall` and `flush` outputs drive the inter-stage pipeline registers of every stage.

## Interface

Parameters:
- `STAGE_NUM`, 5: number of pipeline stages. Index 0 is fetch; index `STAGE_NUM-1` is writeback.
- `ADDR_WIDTH`, 32: width of the redirect target.
- `FLUSH_HOLD`, 2: cycles `flush` stays high per accepted exception. Must be ≥1.
- `RST_PC`, 32'hbfc00000: reset value of `redirect_pc`.
- `CNT_WIDTH`, 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset. Asynchronous, active-low.
- `stall_req`  in  STAGE_NUM: bit i set means stage i cannot advance this cycle.
- `exc_valid`  in  1: exception/redirect request, one-cycle pulse.
- `exc_target`  in  ADDR_WIDTH: redirect address, valid with `exc_valid`.
- `cnt_clr`  in  1: synchronous clear of `stall_cycles`.
- `stall`  out  STAGE_NUM: per-stage stall to the pipeline registers.
- `flush`  out  1: flush to all pipeline registers.
- `redirect_valid`  out  1: one-cycle pulse to fetch.
- `redirect_pc`  out  ADDR_WIDTH: fetch redirect target.
- `stall_cycles`  out  CNT_WIDTH: count of cycles with `stall[0]` high.

## Operation

- **Stall merge (combinational):** `stall[i] = |stall_req[STAGE_NUM-1:i]`.
  - `stall` is forced to all zero while `flush=1` or `rst=0`.
- **FSM states:** IDLE, FLUSH.
- **IDLE:**
  - `exc_valid=1` at a rising edge → go to FLUSH.
  - Load the hold counter with `FLUSH_HOLD-1`.
  - Latch `exc_target` into `redirect_pc`.
  - Set `redirect_valid=1`.
- **FLUSH:**
  - `flush=1`.
  - `redirect_valid` clears after its first cycle.
  - Hold counter decrements each cycle; at 0 → IDLE.
  - `exc_valid` is ignored in FLUSH. Upstream stages are being flushed, so no legal exception can arrive.
- **Simultaneous `exc_valid` and `stall_req` in IDLE:**
  - The exception is accepted.
  - The stall vector is honoured in that same cycle.
  - From the next cycle, the stall vector is suppressed by `flush`.
- **Performance counter (`stall_cycles`):**
  - Increments when `stall[0]=1`, saturating at all-ones.
  - `cnt_clr` has priority over increment.
- **Reset values (rst low, asynchronous):**
  - state IDLE, hold counter 0
  - `flush=0`, `redirect_valid=0`
  - `redirect_pc=RST_PC`
  - `stall_cycles=0`
  - `stall` all zero
- **Reset mid-flush:** immediately aborts to IDLE, with all outputs at their reset values.

## Timing

- `stall` has zero latency from `stall_req` (pure combinational path).
- For `exc_valid` sampled at edge T:
  - `flush=1` from T through the edge at T+FLUSH_HOLD, i.e. exactly FLUSH_HOLD cycles.
  - `redirect_valid=1` for the single cycle following edge T.
  - `redirect_pc` is held until the next accepted exception.
- With `FLUSH_HOLD=1`, FLUSH lasts one cycle. `exc_valid` is accepted again in the next cycle.
- Back-to-back exceptions are spaced at least FLUSH_HOLD+1 edges apart.
- Counter: the edge where `stall[0]=1` is sampled produces the incremented value one cycle later.
- `flush`, `redirect_valid` and `redirect_pc` come directly from registers. No combinational path from inputs.

## Structure

- Shared package `pipeline_pkg` holds:
  - state enum (`PS_IDLE`, `PS_FLUSH`)
  - `STAGE_NUM` default
  - `RST_PC` default constant
- Sub-module `sat_counter` (parameters `WIDTH`; ports `clk`, `rst`, `clr`, `inc`, `count`): saturating counter, reusable by other perf counters.
- Hold counter width is `$clog2(FLUSH_HOLD+1)`, kept inline in the FSM.

## Test plan

All scenarios use default parameters unless stated.
- **Reset:** `rst=0` with `stall_req=5'b11111`, `exc_valid=1` → `stall=0`, `flush=0`, `redirect_valid=0`, `redirect_pc=32'hbfc00000`, `stall_cycles=0`, including when `rst` is asserted mid-cycle.
- **Stall merge:**
  - `stall_req=5'b00100` → `stall=5'b00111`.
  - `stall_req=5'b10000` → `stall=5'b11111`.
  - `stall_req=5'b00001` → `stall=5'b00001`.
- **Exception:** `exc_valid=1`, `exc_target=32'h80000180` at edge T →
  - `flush` high for exactly 2 cycles.
  - `redirect_valid` high for 1 cycle.
  - `redirect_pc=32'h80000180`.
  - `stall` forced to 0 during flush while `stall_req=5'b11111`.
- **Exception during FLUSH:** second `exc_valid` with target `32'h1234` one cycle after T →
  - Ignored.
  - `redirect_pc` stays `32'h80000180`.
  - `flush` still ends after 2 cycles.
- **Counter saturation:** `CNT_WIDTH=4`, `stall_req[0]` held high 20 cycles → `stall_cycles` stops at 15. Then `cnt_clr` together with a stall → 0.
- **Edge case:** `FLUSH_HOLD=1`, with exceptions on edges T and T+2 → two separate one-cycle flushes, and both targets delivered.
